// File: rtl/axrm_pkg.sv
// Shared types and constants for the sequential 8x8 approximate recursive multiplier.
package axrm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          TILE_W              = 2;
  localparam int          NUM_TILES           = 16;
  localparam logic [15:0] DEFAULT_APPROX_MASK = 16'h00FF;

  // Left shift for tile k: operand a row i = k[3:2], operand b column j = k[1:0].
  function automatic logic [3:0] tile_shift(input logic [3:0] k);
    logic [2:0] sum;
    sum = {1'b0, k[3:2]} + {1'b0, k[1:0]};
    return {sum, 1'b0};
  endfunction

endpackage

// File: rtl/axrm_tile_mul2.sv
// Combinational 2x2 tile multiplier; the approximate variant maps 3x3 to 7 instead of 9.
module axrm_tile_mul2 (
  input  logic [1:0] pa,
  input  logic [1:0] pb,
  input  logic       approx_sel,
  output logic [3:0] prod
);

  always_comb begin
    prod = {2'b00, pa} * {2'b00, pb};
    if (approx_sel && (pa == 2'd3) && (pb == 2'd3)) begin
      prod = 4'd7;
    end
  end

endmodule

// File: rtl/axrm_tile_sequencer.sv
// Streams the sixteen 2x2 tiles of an 8x8 product through one shared tile multiplier,
// one tile per clock, accumulating shifted partial products; valid/ready on both sides.
module axrm_tile_sequencer
  import axrm_pkg::*;
#(
  parameter logic [15:0] APPROX_MASK = DEFAULT_APPROX_MASK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        approx_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_TILES - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] mask_q;
  logic [15:0] acc;

  logic [1:0]  pa;
  logic [1:0]  pb;
  logic        tile_approx;
  logic [3:0]  tile_prod;
  logic [15:0] acc_next;

  assign pa          = a_q[{idx[3:2], 1'b0} +: TILE_W];
  assign pb          = b_q[{idx[1:0], 1'b0} +: TILE_W];
  assign tile_approx = mask_q[idx];
  assign acc_next    = acc + ({12'd0, tile_prod} << tile_shift(idx));

  axrm_tile_mul2 u_tile_mul2 (
    .pa         (pa),
    .pb         (pb),
    .approx_sel (tile_approx),
    .prod       (tile_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 4'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      mask_q    <= 16'd0;
      acc       <= 16'd0;
      result    <= 16'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            mask_q   <= approx_en ? APPROX_MASK : 16'd0;
            acc      <= 16'd0;
            idx      <= 4'd0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_next;
          idx <= idx + 4'd1;
          // The final tile's contribution goes straight to result, so DONE needs no extra add.
          if (idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axrm_tile_sequencer.sv
// Directed and randomised checks of the tile sequencer against an exact-minus-loss model.
module tb_axrm_tile_sequencer;

  localparam logic [15:0] MASK = 16'h00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axrm_tile_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each approximate tile that sees 3x3 loses 2 at that tile's weight.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic en);
    int p;
    p = int'(x) * int'(y);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (en && MASK[4*i+j] && (((x >> (2*i)) & 8'd3) == 8'd3) && (((y >> (2*j)) & 8'd3) == 8'd3))
          p = p - (2 << (2*(i+j)));
      end
    end
    return 16'(p);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // lat counts the accept cycle as cycle 0, so a 16-tile run plus DONE reads 17.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic en, input int stall,
                        output logic [15:0] res, output int lat);
    int n;
    wait_ready();
    a = x; b = y; approx_en = en; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); approx_en = 1'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    lat = n + 1;
    res = result;
    repeat (stall) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] res;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        en;
    int          lat;
    int          n;
    int          t_first;
    int          t_second;

    rst = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0; approx_en = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    run_op(8'hFF, 8'hFF, 1'b0, 0, res, lat);
    check("exact_ff_ff", 32'(res), 32'd65025);
    check("exact_latency", 32'(lat), 32'd17);
    check("idle_after_take", 32'(out_valid), 32'd0);

    run_op(8'hFF, 8'hFF, 1'b1, 0, res, lat);
    check("approx_ff_ff", 32'(res), 32'd64175);
    check("approx_latency", 32'(lat), 32'd17);

    run_op(8'h0F, 8'h0F, 1'b1, 1, res, lat);
    check("approx_0f_0f", 32'(res), 32'd175);
    run_op(8'hF0, 8'h0F, 1'b1, 2, res, lat);
    check("approx_f0_0f", 32'(res), 32'd3600);

    // Stalled consumer: result must hold and new offers must be refused.
    wait_ready();
    a = 8'h5A; b = 8'hC3; approx_en = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("stall_valid_seen", 32'(out_valid), 32'd1);
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1; a = 8'h11; b = 8'h22; approx_en = 1'b1;
      step();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_result", 32'(result), 32'd17550);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    run_op(8'h0F, 8'h0F, 1'b1, 0, res, lat);
    check("after_stall_op", 32'(res), 32'd175);

    // Abort mid-run at tile 7.
    wait_ready();
    a = 8'hFF; b = 8'hFF; approx_en = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    run_op(8'd3, 8'd3, 1'b0, 0, res, lat);
    check("post_abort_3x3", 32'(res), 32'd9);
    check("post_abort_latency", 32'(lat), 32'd17);

    // Back-to-back with both sides always willing: IDLE recurs every 18 cycles.
    t_first = -1; t_second = -1;
    a = 8'hA5; b = 8'h3C; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (in_ready) begin
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
      if (out_valid) check("tput_result", 32'(result), 32'(ref_mul(8'hA5, 8'h3C, 1'b1)));
      step();
    end
    check("tput_period", 32'(t_second - t_first), 32'd18);
    in_valid = 1'b0;
    wait_ready();
    out_ready = 1'b0;

    for (int r = 0; r < 500; r++) begin
      x  = 8'($urandom);
      y  = 8'($urandom);
      en = 1'($urandom);
      if (r % 7 == 0) x = 8'hFF;
      if (r % 5 == 0) y = 8'hFF;
      repeat ($urandom_range(0, 2)) step();
      run_op(x, y, en, int'($urandom_range(0, 3)), res, lat);
      check("random_op", 32'(res), 32'(ref_mul(x, y, en)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
